// File: rtl/decoder_scan_sequencer.sv
// Select-line sequencer for a 4-to-16 decoder: free-run scan, single step,
// preload and stop, each code held for DWELL cycles with a tick on the last.
module decoder_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int LAST  = 15,
  parameter bit WRAP  = 1'b0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       step_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       x_o,
  output logic       y_o,
  output logic       z_o,
  output logic       w_o,
  output logic       enable_o,
  output logic       tick_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // A zero dwell behaves as one cycle; anything above 255 is clamped.
  localparam int         DW        = (DWELL < 1) ? 1 : ((DWELL > 255) ? 255 : DWELL);
  localparam logic [7:0] CNT_LAST  = 8'(DW - 1);
  localparam logic [3:0] CODE_LAST = 4'(LAST);

  logic [1:0] state_q, state_d;
  logic [3:0] code_q, code_d;
  logic [7:0] cnt_q, cnt_d;
  logic       enable_q, tick_q, busy_q, done_q;
  logic       active_d;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // stop outranks everything, so it masks start/step/load while idle
        if (!stop_i) begin
          if (start_i) begin
            state_d = S_SCAN;
            cnt_d   = 8'd0;
          end else if (step_i) begin
            state_d = S_STEP;
            cnt_d   = 8'd0;
          end else if (load_i) begin
            code_d = load_val_i;
          end
        end
      end
      S_SCAN: begin
        if (stop_i) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = 8'd0;
          if (code_q == CODE_LAST) begin
            if (WRAP) code_d  = 4'd0;
            else      state_d = S_DONE;
          end else begin
            code_d = code_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_STEP: begin
        if (stop_i) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          code_d  = code_q + 4'd1;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with the state.
  assign active_d = (state_d == S_SCAN) || (state_d == S_STEP);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      code_q   <= 4'd0;
      cnt_q    <= 8'd0;
      enable_q <= 1'b0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      enable_q <= active_d;
      tick_q   <= active_d && (cnt_d == CNT_LAST);
      busy_q   <= active_d;
      done_q   <= (state_d == S_DONE);
    end
  end

  assign {x_o, y_o, z_o, w_o} = code_q;
  assign enable_o = enable_q;
  assign tick_o   = tick_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Random + directed bench for decoder_scan_sequencer: four parameterizations
// share one stimulus stream and are checked against a countdown reference model.
module tb_decoder_scan_sequencer;

  localparam int NI = 4;
  localparam int DW_T  [NI] = '{4, 2, 1, 0};
  localparam int LST_T [NI] = '{15, 15, 5, 9};
  localparam bit WRP_T [NI] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       reset, start, stop, step, load;
  logic [3:0] load_val;
  logic [7:0] obs [NI];

  int n_chk  = 0;
  int n_fail = 0;

  // model: mode 0 idle, 1 scan, 2 step, 3 done; rem = cycles left of this dwell
  int md  [NI];
  int cd  [NI];
  int rem [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic x, y, z, w, en, tk, bz, dn;
    decoder_scan_sequencer #(.DWELL(DW_T[g]), .LAST(LST_T[g]), .WRAP(WRP_T[g])) u_dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .stop_i(stop), .step_i(step),
      .load_i(load), .load_val_i(load_val),
      .x_o(x), .y_o(y), .z_o(z), .w_o(w),
      .enable_o(en), .tick_o(tk), .busy_o(bz), .done_o(dn)
    );
    assign obs[g] = {x, y, z, w, en, tk, bz, dn};
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got xyzw_en_tk_bz_dn=%b exp %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < NI; i++) begin
      int d;
      d = (DW_T[i] < 1) ? 1 : DW_T[i];
      if (reset) begin
        md[i] = 0; cd[i] = 0; rem[i] = 0;
      end else begin
        case (md[i])
          0: if (!stop) begin
               if (start)     begin md[i] = 1; rem[i] = d; end
               else if (step) begin md[i] = 2; rem[i] = d; end
               else if (load) cd[i] = int'(load_val);
             end
          1: if (stop) md[i] = 0;
             else if (rem[i] > 1) rem[i]--;
             else if (cd[i] == LST_T[i]) begin
               if (WRP_T[i]) begin cd[i] = 0; rem[i] = d; end
               else md[i] = 3;
             end else begin
               cd[i] = (cd[i] + 1) % 16; rem[i] = d;
             end
          2: if (stop) md[i] = 0;
             else if (rem[i] > 1) rem[i]--;
             else begin cd[i] = (cd[i] + 1) % 16; md[i] = 0; end
          default: md[i] = 0;
        endcase
      end
    end
  endtask

  function automatic logic [7:0] expect_of(input int i);
    logic act;
    logic [3:0] c;
    act = (md[i] == 1) || (md[i] == 2);
    c   = cd[i][3:0];
    return {c, act, act && (rem[i] == 1), act, md[i] == 3};
  endfunction

  // one clock with the given commands; model advances at the edge, check 1 later
  task automatic cyc(input logic r, input logic sa, input logic so, input logic se,
                     input logic ld, input logic [3:0] lv);
    @(negedge clk);
    reset = r; start = sa; stop = so; step = se; load = ld; load_val = lv;
    @(posedge clk);
    model_update();
    #1;
    for (int i = 0; i < NI; i++) chk($sformatf("dut%0d", i), obs[i], expect_of(i));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 4'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; load = 1'b0; load_val = 4'd0;
    cyc(1, 0, 0, 0, 0, 4'd0);
    cyc(1, 0, 0, 0, 0, 4'd0);
    // load 3 and scan through 3 into 4
    cyc(0, 0, 0, 0, 1, 4'd3);
    cyc(0, 1, 0, 0, 0, 4'd0);
    idle(10);
    cyc(0, 0, 1, 0, 0, 4'd0);
    idle(2);
    // scan from 14: non-wrap end, wrap at 15, start above LAST
    cyc(0, 0, 0, 0, 1, 4'd14);
    cyc(0, 1, 0, 0, 0, 4'd0);
    idle(24);
    cyc(0, 0, 1, 0, 0, 4'd0);
    // stop mid-dwell on code 6 then restart
    cyc(0, 0, 0, 0, 1, 4'd6);
    cyc(0, 1, 0, 0, 0, 4'd0);
    idle(1);
    cyc(0, 0, 1, 0, 0, 4'd0);
    idle(2);
    cyc(0, 1, 0, 0, 0, 4'd0);
    idle(5);
    cyc(0, 0, 1, 0, 0, 4'd0);
    // step at 15, then start+stop together
    cyc(0, 0, 0, 0, 1, 4'd15);
    cyc(0, 0, 0, 1, 0, 4'd0);
    idle(6);
    cyc(0, 1, 1, 0, 0, 4'd0);
    idle(2);
    // reset held two cycles mid-scan
    cyc(0, 1, 0, 0, 0, 4'd0);
    idle(3);
    cyc(1, 0, 0, 0, 0, 4'd0);
    cyc(1, 0, 0, 0, 0, 4'd0);
    idle(2);
    for (int k = 0; k < 4000; k++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
